// File: rtl/serial_bcd_add_seq.sv
// Initiator/sequencer for a digit-serial BCD adder: parallel operands in, LSD-first serial frame out, parallel sum back.
// Optional operand digit check enabled by defining SERIAL_BCD_SEQ_BCD_CHECK_EN.
module serial_bcd_add_seq #(
  parameter int NDIG = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [4*NDIG-1:0]       op_a,
  input  logic [4*NDIG-1:0]       op_b,
  output logic [3:0]              a,
  output logic [3:0]              b,
  output logic                    start,
  output logic                    done,
  input  logic [3:0]              sum,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [4*(NDIG+1)-1:0]   rsp_sum,
  output logic                    rsp_err
);

  localparam int KW = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam int OW = 4 * NDIG;
  localparam int RW = 4 * (NDIG + 1);

  typedef enum logic [1:0] {IDLE, SEND, FINISH, RESP} state_t;

  state_t          state, state_next;
  logic [KW-1:0]   k, k_next;
  logic [OW-1:0]   sh_a, sh_a_next, sh_b, sh_b_next;
  logic [3:0]      a_next, b_next;
  logic            start_next, done_next, rsp_valid_next;
  logic [RW-1:0]   rsp_sum_next;
  logic            accept;

  assign req_ready = (state == IDLE);
  assign accept    = req_valid & req_ready;

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
    state_next     = state;
    k_next         = k;
    sh_a_next      = sh_a;
    sh_b_next      = sh_b;
    a_next         = 4'd0;
    b_next         = 4'd0;
    start_next     = 1'b0;
    done_next      = 1'b0;
    rsp_valid_next = rsp_valid;
    rsp_sum_next   = rsp_sum;
    case (state)
      IDLE: begin
        if (accept) begin
          state_next = SEND;
          k_next     = '0;
          a_next     = op_a[3:0];
          b_next     = op_b[3:0];
          start_next = 1'b1;
          sh_a_next  = op_a >> 4;
          sh_b_next  = op_b >> 4;
        end
      end
      SEND: begin
        // Result shifts in from the top so the first captured digit lands at bit 0 after NDIG+1 captures.
        rsp_sum_next = {sum, rsp_sum[RW-1:4]};
        if (k == KW'(NDIG - 1)) begin
          state_next = FINISH;
          done_next  = 1'b1;
        end else begin
          k_next    = k + 1'b1;
          a_next    = sh_a[3:0];
          b_next    = sh_b[3:0];
          sh_a_next = sh_a >> 4;
          sh_b_next = sh_b >> 4;
        end
      end
      FINISH: begin
        rsp_sum_next   = {sum, rsp_sum[RW-1:4]};
        rsp_valid_next = 1'b1;
        state_next     = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_next = 1'b0;
          state_next     = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      k         <= '0;
      sh_a      <= '0;
      sh_b      <= '0;
      a         <= 4'd0;
      b         <= 4'd0;
      start     <= 1'b0;
      done      <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_sum   <= '0;
    end else begin
      state     <= state_next;
      k         <= k_next;
      sh_a      <= sh_a_next;
      sh_b      <= sh_b_next;
      a         <= a_next;
      b         <= b_next;
      start     <= start_next;
      done      <= done_next;
      rsp_valid <= rsp_valid_next;
      rsp_sum   <= rsp_sum_next;
    end
  end

`ifdef SERIAL_BCD_SEQ_BCD_CHECK_EN
  function automatic logic has_bad_digit(input logic [OW-1:0] v);
    for (int i = 0; i < NDIG; i++) begin
      if (v[4*i +: 4] > 4'd9) return 1'b1;
    end
    return 1'b0;
  endfunction

  // Flag is taken once per request and held until the next acceptance.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_err <= 1'b0;
    end else if (accept) begin
      rsp_err <= has_bad_digit(op_a) | has_bad_digit(op_b);
    end
  end
`else
  assign rsp_err = 1'b0;
`endif

endmodule
